// File: rtl/ember_lsu_pkg.sv
// Shared definitions for the Ember load/store unit: access sizes, FSM states
// and the alignment check used at request accept.
package ember_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // An access is misaligned when its byte offset is not a multiple of its size.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic bad;
    unique case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ember_lsu_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge
// over a 64-bit little-endian word.
module ember_lsu_lane
  import ember_lsu_pkg::*;
(
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [63:0] ld_data,
  output logic [63:0] st_word
);

  logic [5:0]  sh;
  logic [63:0] size_mask;
  logic [63:0] shifted;
  logic [63:0] masked;
  logic [63:0] lane_mask;
  logic        sign_bit;

  always_comb begin
    sh        = {off, 3'b000};
    size_mask = '1;
    sign_bit  = 1'b0;
    shifted   = old_word >> sh;
    unique case (size)
      SZ_B: begin size_mask = 64'h0000_0000_0000_00FF; sign_bit = shifted[7];  end
      SZ_H: begin size_mask = 64'h0000_0000_0000_FFFF; sign_bit = shifted[15]; end
      SZ_W: begin size_mask = 64'h0000_0000_FFFF_FFFF; sign_bit = shifted[31]; end
      default: begin size_mask = '1;                   sign_bit = shifted[63]; end
    endcase
    masked    = shifted & size_mask;
    // Sign extension fills every bit above the access width.
    ld_data   = (is_signed && sign_bit) ? (masked | ~size_mask) : masked;
    lane_mask = size_mask << sh;
    st_word   = (old_word & ~lane_mask) | ((wdata << sh) & lane_mask);
  end

endmodule

// File: rtl/ember_lsu.sv
// Ember load/store unit: one request in flight, loads with extend, sub-word
// stores as read-modify-write against a 64-bit word memory.
module ember_lsu
  import ember_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  state_t      state, state_nx;
  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [2:0]  r_off;
  logic [DATA_W-1:0] r_wdata;
  logic        accept;
  logic        req_bad;
  logic [63:0] ld_data;
  logic [63:0] st_word;

  ember_lsu_lane u_lane (
    .old_word  (mem_rd_data),
    .wdata     (r_wdata),
    .off       (r_off),
    .size      (r_size),
    .is_signed (r_signed),
    .ld_data   (ld_data),
    .st_word   (st_word)
  );

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_bad   = misaligned(req_addr[2:0], req_size);

  always_comb begin
    state_nx   = state;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                          state_nx = RESP;
          else if (req_we && req_size == SZ_D)  state_nx = WR;
          else                                  state_nx = RD;
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        state_nx  = RDW;
      end
      RDW:  state_nx = r_we ? WR : RESP;
      WR: begin
        mem_wr_en = 1'b1;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= SZ_B;
      r_off       <= '0;
      r_wdata     <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_we        <= req_we;
        r_signed    <= req_signed;
        r_size      <= req_size;
        r_off       <= req_addr[2:0];
        r_wdata     <= req_wdata;
        mem_addr    <= req_addr >> 3;
        // Dword stores go straight to WR, so their write data is taken here.
        mem_wr_data <= req_wdata;
        resp_rdata  <= '0;
        resp_err    <= req_bad;
      end
      if (state == RDW) begin
        if (r_we) mem_wr_data <= st_word;
        else      resp_rdata  <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_ember_lsu.sv
// Directed bench for ember_lsu against a bench-side word memory model.
module tb_ember_lsu;
  import ember_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [63:0] mem_rd_data;

  logic [63:0] mem [0:255];
  int total = 0;
  int bad   = 0;
  logic both_hi = 1'b0;

  always #5 clk = ~clk;

  ember_lsu #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[7:0]];
  end

  always @(negedge clk) if (mem_rd_en && mem_wr_en) both_hi = 1'b1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [63:0] exp_word;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [0:18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [63:0] wdata,
                              input logic [63:0] er, input logic ee, input int el,
                              input logic [63:0] ew, input int nr, input int nw);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_word = ew;
    v.exp_rd = nr; v.exp_wr = nw;
    return v;
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [63:0] wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run(input vec_t v, input int idx);
    int lat, nr, nw;
    logic addr_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(v.we, v.size, v.sgn, v.addr, v.wdata);
    lat = 0; nr = 0; nw = 0; addr_ok = 1'b1;
    while (!resp_valid && lat < 20) begin
      if (mem_rd_en) nr++;
      if (mem_wr_en) nw++;
      if ((mem_rd_en || mem_wr_en) && mem_addr != (v.addr >> 3)) addr_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},   64'(lat), 64'(v.exp_lat));
    chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, "_err"},   64'(resp_err), 64'(v.exp_err));
    chk({tag, "_strb"},  64'({nr[7:0], nw[7:0]}), 64'({v.exp_rd[7:0], v.exp_wr[7:0]}));
    chk({tag, "_maddr"}, 64'(addr_ok), 64'd1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_done"},  64'({resp_valid, req_ready}), 64'b01);
    chk({tag, "_word"},  mem[8'(v.addr >> 3)], v.exp_word);
  endtask

  initial begin
    logic ok;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_B; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    vecs[0]  = mk(1, SZ_D, 0, 32'h40, 64'h1122334455667788, 64'h0, 0, 1, 64'h1122334455667788, 0, 1);
    vecs[1]  = mk(0, SZ_D, 0, 32'h40, 64'h0, 64'h1122334455667788, 0, 2, 64'h1122334455667788, 1, 0);
    vecs[2]  = mk(1, SZ_H, 0, 32'h44, 64'hCAFE00000000BEEF, 64'h0, 0, 3, 64'h1122BEEF55667788, 1, 1);
    vecs[3]  = mk(0, SZ_W, 0, 32'h44, 64'h0, 64'h000000001122BEEF, 0, 2, 64'h1122BEEF55667788, 1, 0);
    vecs[4]  = mk(1, SZ_H, 0, 32'h40, 64'h00000000000080FF, 64'h0, 0, 3, 64'h1122BEEF556680FF, 1, 1);
    vecs[5]  = mk(0, SZ_B, 1, 32'h41, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 2, 64'h1122BEEF556680FF, 1, 0);
    vecs[6]  = mk(0, SZ_B, 0, 32'h40, 64'h0, 64'h00000000000000FF, 0, 2, 64'h1122BEEF556680FF, 1, 0);
    vecs[7]  = mk(0, SZ_B, 1, 32'h40, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 2, 64'h1122BEEF556680FF, 1, 0);
    vecs[8]  = mk(0, SZ_H, 1, 32'h40, 64'h0, 64'hFFFFFFFFFFFF80FF, 0, 2, 64'h1122BEEF556680FF, 1, 0);
    vecs[9]  = mk(1, SZ_B, 0, 32'h47, 64'h00000000000000A5, 64'h0, 0, 3, 64'hA522BEEF556680FF, 1, 1);
    vecs[10] = mk(0, SZ_W, 1, 32'h44, 64'h0, 64'hFFFFFFFFA522BEEF, 0, 2, 64'hA522BEEF556680FF, 1, 0);
    vecs[11] = mk(0, SZ_H, 0, 32'h46, 64'h0, 64'h000000000000A522, 0, 2, 64'hA522BEEF556680FF, 1, 0);
    vecs[12] = mk(0, SZ_W, 0, 32'h42, 64'h0, 64'h0, 1, 0, 64'hA522BEEF556680FF, 0, 0);
    vecs[13] = mk(1, SZ_H, 0, 32'h43, 64'h1234, 64'h0, 1, 0, 64'hA522BEEF556680FF, 0, 0);
    vecs[14] = mk(1, SZ_D, 0, 32'h44, 64'h0123456789ABCDEF, 64'h0, 1, 0, 64'hA522BEEF556680FF, 0, 0);
    vecs[15] = mk(0, SZ_D, 0, 32'h40, 64'h0, 64'hA522BEEF556680FF, 0, 2, 64'hA522BEEF556680FF, 1, 0);
    vecs[16] = mk(0, SZ_H, 1, 32'h41, 64'h0, 64'h0, 1, 0, 64'hA522BEEF556680FF, 0, 0);
    vecs[17] = mk(1, SZ_W, 0, 32'h40, 64'hFFFFFFFF01234567, 64'h0, 0, 3, 64'hA522BEEF01234567, 1, 1);
    vecs[18] = mk(0, SZ_W, 1, 32'h40, 64'h0, 64'h0000000001234567, 0, 2, 64'hA522BEEF01234567, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_outs", 64'({resp_valid, resp_err, mem_rd_en, mem_wr_en}), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_maddr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wr_data, 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 19; i++) run(vecs[i], i);

    // Backpressure: response held while a competing request waits.
    issue(1'b0, SZ_D, 1'b0, 32'h40, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_B; req_addr = 32'h48;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!resp_valid || resp_rdata !== 64'hA522BEEF01234567 || resp_err || req_ready ||
          mem_rd_en || mem_wr_en) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    chk("bp_rdata", resp_rdata, 64'hA522BEEF01234567);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_release", 64'({resp_valid, req_ready}), 64'b01);

    // Reset during RDW of a sub-word store abandons it.
    issue(1'b1, SZ_H, 1'b0, 32'h40, 64'h0000000000001234);
    chk("mr_rd", 64'(mem_rd_en), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mr_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_outs", 64'({resp_valid, resp_err, mem_rd_en, mem_wr_en}), 64'd0);
    chk("mr_rdata", resp_rdata, 64'd0);
    chk("mr_maddr", 64'(mem_addr), 64'd0);
    chk("mr_wdata", mem_wr_data, 64'd0);
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (mem_wr_en || resp_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("mr_quiet", 64'(ok), 64'd1);
    chk("mr_word", mem[8], 64'hA522BEEF01234567);
    run(mk(0, SZ_D, 0, 32'h40, 64'h0, 64'hA522BEEF01234567, 0, 2, 64'hA522BEEF01234567, 1, 0), 99);

    chk("strobe_excl", 64'(both_hi), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
